// File: rtl/zap_alu_main.sv
// zap_alu_main: execute stage following the shifter. Evaluates the ARM
// condition code against the live NZCV flags, computes the ALU result and
// next flags, requests a fetch redirect on PC writes or mispredicted branches,
// and registers the instruction for the memory stage.
module zap_alu_main #(
    parameter int PHY_REGS = 46,
    parameter int ALU_OPS  = 32,
    parameter int PC_INDEX = 15
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_clear_from_writeback,
    input  logic                        i_data_stall,
    input  logic [3:0]                  i_condition_code_ff,
    input  logic [$clog2(ALU_OPS)-1:0]  i_alu_operation_ff,
    input  logic                        i_flag_update_ff,
    input  logic [$clog2(PHY_REGS)-1:0] i_destination_index_ff,
    input  logic [31:0]                 i_alu_source_value_ff,
    input  logic [31:0]                 i_shifted_source_value_ff,
    input  logic                        i_shift_carry_ff,
    input  logic                        i_rrx_ff,
    input  logic                        i_use_old_carry_ff,
    input  logic [31:0]                 i_pc_plus_8_ff,
    input  logic [31:0]                 i_pc_ff,
    input  logic                        i_taken_ff,
    input  logic [8:0]                  i_mem_ctrl_ff,
    input  logic [$clog2(PHY_REGS)-1:0] i_mem_srcdest_index_ff,
    input  logic [31:0]                 i_mem_srcdest_value_ff,
    input  logic [4:0]                  i_exc_ff,
    output logic [31:0]                 o_alu_value_nxt,
    output logic [3:0]                  o_cpsr_flags_nxt,
    output logic                        o_clear_from_alu,
    output logic [31:0]                 o_pc_from_alu,
    output logic [31:0]                 o_alu_result_ff,
    output logic [$clog2(PHY_REGS)-1:0] o_destination_index_ff,
    output logic                        o_dav_ff,
    output logic [3:0]                  o_flags_ff,
    output logic [8:0]                  o_mem_ctrl_ff,
    output logic [$clog2(PHY_REGS)-1:0] o_mem_srcdest_index_ff,
    output logic [31:0]                 o_mem_srcdest_value_ff,
    output logic [4:0]                  o_exc_ff,
    output logic [31:0]                 o_pc_plus_8_ff
);

    localparam int OP_W  = $clog2(ALU_OPS);
    localparam int IDX_W = $clog2(PHY_REGS);

    // Opcode encodings follow the ARM data-processing field; higher encodings
    // fall back to a plain move of operand B.
    localparam logic [OP_W-1:0] OP_AND = OP_W'(0);
    localparam logic [OP_W-1:0] OP_EOR = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(2);
    localparam logic [OP_W-1:0] OP_RSB = OP_W'(3);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(4);
    localparam logic [OP_W-1:0] OP_ADC = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SBC = OP_W'(6);
    localparam logic [OP_W-1:0] OP_RSC = OP_W'(7);
    localparam logic [OP_W-1:0] OP_TST = OP_W'(8);
    localparam logic [OP_W-1:0] OP_TEQ = OP_W'(9);
    localparam logic [OP_W-1:0] OP_CMP = OP_W'(10);
    localparam logic [OP_W-1:0] OP_CMN = OP_W'(11);
    localparam logic [OP_W-1:0] OP_ORR = OP_W'(12);
    localparam logic [OP_W-1:0] OP_MOV = OP_W'(13);
    localparam logic [OP_W-1:0] OP_BIC = OP_W'(14);
    localparam logic [OP_W-1:0] OP_MVN = OP_W'(15);

    logic [31:0]      alu_result_q, alu_result_d;
    logic [IDX_W-1:0] destination_index_q, destination_index_d;
    logic             dav_q, dav_d;
    logic [3:0]       flags_q, flags_d;
    logic [8:0]       mem_ctrl_q, mem_ctrl_d;
    logic [IDX_W-1:0] mem_srcdest_index_q, mem_srcdest_index_d;
    logic [31:0]      mem_srcdest_value_q, mem_srcdest_value_d;
    logic [4:0]       exc_q, exc_d;
    logic [31:0]      pc_plus_8_q, pc_plus_8_d;

    logic        flag_n, flag_z, flag_c, flag_v;
    logic        cc_ok;
    logic [31:0] op_a, op_b;
    logic [31:0] add_a, add_b;
    logic        add_cin;
    logic [32:0] sum;
    logic        is_arith, is_test;
    logic [31:0] result;
    logic        res_c, res_v;
    logic        flags_write;
    logic        inst_dav;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    // Standard ARM condition evaluation against the architectural flags.
    always_comb begin
        cc_ok = 1'b0;
        case (i_condition_code_ff)
            4'd0:    cc_ok = flag_z;
            4'd1:    cc_ok = !flag_z;
            4'd2:    cc_ok = flag_c;
            4'd3:    cc_ok = !flag_c;
            4'd4:    cc_ok = flag_n;
            4'd5:    cc_ok = !flag_n;
            4'd6:    cc_ok = flag_v;
            4'd7:    cc_ok = !flag_v;
            4'd8:    cc_ok = flag_c && !flag_z;
            4'd9:    cc_ok = !flag_c || flag_z;
            4'd10:   cc_ok = (flag_n == flag_v);
            4'd11:   cc_ok = (flag_n != flag_v);
            4'd12:   cc_ok = !flag_z && (flag_n == flag_v);
            4'd13:   cc_ok = flag_z || (flag_n != flag_v);
            4'd14:   cc_ok = 1'b1;
            default: cc_ok = 1'b0;
        endcase
    end

    assign op_a = i_alu_source_value_ff;
    assign op_b = i_rrx_ff ? {flag_c, i_shifted_source_value_ff[31:1]}
                           : i_shifted_source_value_ff;

    // Operation decode, 33-bit adder and result/carry/overflow selection;
    // subtraction is addition of the inverted operand so C means NOT borrow.
    always_comb begin
        add_a    = op_a;
        add_b    = op_b;
        add_cin  = 1'b0;
        is_arith = 1'b0;
        is_test  = 1'b0;
        result   = op_b;
        case (i_alu_operation_ff)
            OP_AND:  result = op_a & op_b;
            OP_EOR:  result = op_a ^ op_b;
            OP_ORR:  result = op_a | op_b;
            OP_MOV:  result = op_b;
            OP_BIC:  result = op_a & ~op_b;
            OP_MVN:  result = ~op_b;
            OP_TST:  begin result = op_a & op_b; is_test = 1'b1; end
            OP_TEQ:  begin result = op_a ^ op_b; is_test = 1'b1; end
            OP_ADD:  is_arith = 1'b1;
            OP_ADC:  begin is_arith = 1'b1; add_cin = flag_c; end
            OP_SUB:  begin is_arith = 1'b1; add_b = ~op_b; add_cin = 1'b1; end
            OP_SBC:  begin is_arith = 1'b1; add_b = ~op_b; add_cin = flag_c; end
            OP_RSB:  begin is_arith = 1'b1; add_a = op_b; add_b = ~op_a; add_cin = 1'b1; end
            OP_RSC:  begin is_arith = 1'b1; add_a = op_b; add_b = ~op_a; add_cin = flag_c; end
            OP_CMP:  begin is_arith = 1'b1; is_test = 1'b1; add_b = ~op_b; add_cin = 1'b1; end
            OP_CMN:  begin is_arith = 1'b1; is_test = 1'b1; end
            default: result = op_b;
        endcase
        sum = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
        if (is_arith) begin
            result = sum[31:0];
            res_c  = sum[32];
            res_v  = (add_a[31] == add_b[31]) && (sum[31] != add_a[31]);
        end else begin
            res_c  = i_use_old_carry_ff ? flag_c : i_shift_carry_ff;
            res_v  = flag_v;
        end
    end

    assign flags_write      = cc_ok && (i_flag_update_ff || is_test);
    assign inst_dav         = cc_ok && !is_test;
    assign o_alu_value_nxt  = cc_ok ? result : op_b;
    assign o_cpsr_flags_nxt = flags_write ? {result[31], (result == 32'd0), res_c, res_v}
                                          : flags_q;

    // Redirect on a taken PC write or a predicted-taken branch that fails its
    // condition; suppressed while the pipeline is held or being flushed.
    always_comb begin
        o_clear_from_alu = 1'b0;
        o_pc_from_alu    = 32'd0;
        if (!i_data_stall && !i_clear_from_writeback) begin
            if (inst_dav && (i_destination_index_ff == IDX_W'(PC_INDEX))) begin
                o_clear_from_alu = 1'b1;
                o_pc_from_alu    = {result[31:1], 1'b0};
            end else if (i_taken_ff && !cc_ok) begin
                o_clear_from_alu = 1'b1;
                o_pc_from_alu    = i_pc_ff + 32'd4;
            end
        end
    end

    // Next register state: a writeback flush empties the stage but keeps the
    // flags, a stall holds everything, otherwise the instruction is captured.
    always_comb begin
        alu_result_d        = alu_result_q;
        destination_index_d = destination_index_q;
        dav_d               = dav_q;
        flags_d             = flags_q;
        mem_ctrl_d          = mem_ctrl_q;
        mem_srcdest_index_d = mem_srcdest_index_q;
        mem_srcdest_value_d = mem_srcdest_value_q;
        exc_d               = exc_q;
        pc_plus_8_d         = pc_plus_8_q;
        if (i_clear_from_writeback) begin
            alu_result_d        = 32'd0;
            destination_index_d = '0;
            dav_d               = 1'b0;
            mem_ctrl_d          = 9'd0;
            mem_srcdest_index_d = '0;
            mem_srcdest_value_d = 32'd0;
            exc_d               = 5'd0;
            pc_plus_8_d         = 32'd0;
        end else if (!i_data_stall) begin
            alu_result_d        = o_alu_value_nxt;
            destination_index_d = i_destination_index_ff;
            dav_d               = inst_dav;
            flags_d             = o_cpsr_flags_nxt;
            mem_ctrl_d          = i_mem_ctrl_ff;
            mem_srcdest_index_d = i_mem_srcdest_index_ff;
            mem_srcdest_value_d = i_mem_srcdest_value_ff;
            exc_d               = i_exc_ff;
            pc_plus_8_d         = i_pc_plus_8_ff;
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            alu_result_q        <= 32'd0;
            destination_index_q <= '0;
            dav_q               <= 1'b0;
            flags_q             <= 4'd0;
            mem_ctrl_q          <= 9'd0;
            mem_srcdest_index_q <= '0;
            mem_srcdest_value_q <= 32'd0;
            exc_q               <= 5'd0;
            pc_plus_8_q         <= 32'd0;
        end else begin
            alu_result_q        <= alu_result_d;
            destination_index_q <= destination_index_d;
            dav_q               <= dav_d;
            flags_q             <= flags_d;
            mem_ctrl_q          <= mem_ctrl_d;
            mem_srcdest_index_q <= mem_srcdest_index_d;
            mem_srcdest_value_q <= mem_srcdest_value_d;
            exc_q               <= exc_d;
            pc_plus_8_q         <= pc_plus_8_d;
        end
    end

    assign o_alu_result_ff        = alu_result_q;
    assign o_destination_index_ff = destination_index_q;
    assign o_dav_ff               = dav_q;
    assign o_flags_ff             = flags_q;
    assign o_mem_ctrl_ff          = mem_ctrl_q;
    assign o_mem_srcdest_index_ff = mem_srcdest_index_q;
    assign o_mem_srcdest_value_ff = mem_srcdest_value_q;
    assign o_exc_ff               = exc_q;
    assign o_pc_plus_8_ff         = pc_plus_8_q;

endmodule
